// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - multi-port register file with per-register producer scoreboard
// Combinational reads with writeback bypass; reservation, tag-qualified writeback and flush on clk.
module scoreboard_regfile #(
   parameter int xlen           = 32,
   parameter int reg_cnt        = 32,
   parameter int read_port_cnt  = 4,
   parameter int write_port_cnt = 2,
   parameter int tag_w          = 4,
   localparam int aw            = $clog2(reg_cnt)
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              en,
   input  logic [read_port_cnt*aw-1:0]       rd_addr,
   output logic [read_port_cnt*xlen-1:0]     rd_data,
   output logic [read_port_cnt-1:0]          rd_busy,
   output logic [read_port_cnt*tag_w-1:0]    rd_tag,
   input  logic                              rsv_en,
   input  logic [aw-1:0]                     rsv_addr,
   input  logic [tag_w-1:0]                  rsv_tag,
   input  logic [write_port_cnt-1:0]         wb_en,
   input  logic [write_port_cnt*aw-1:0]      wb_addr,
   input  logic [write_port_cnt*xlen-1:0]    wb_data,
   input  logic [write_port_cnt*tag_w-1:0]   wb_tag,
   input  logic                              flush
);

   // Flat views of the state; slot 0 is tied to zero since x0 has no storage.
   logic [reg_cnt*xlen-1:0]  val_flat;
   logic [reg_cnt-1:0]       busy_flat;
   logic [reg_cnt*tag_w-1:0] tag_flat;

   assign val_flat[xlen-1:0]  = '0;
   assign busy_flat[0]        = 1'b0;
   assign tag_flat[tag_w-1:0] = '0;

   for (genvar r = 1; r < reg_cnt; r++) begin : g_reg
      localparam logic [aw-1:0] ra = aw'(r);

      logic [xlen-1:0]  value_q;
      logic             busy_q;
      logic [tag_w-1:0] tag_q;
      logic             wr_hit;
      logic             tag_hit;
      logic [xlen-1:0]  wr_val;
      logic             rsv_hit;

      // Later ports override earlier ones, so the highest matching port supplies the data.
      always_comb begin
         wr_hit  = 1'b0;
         tag_hit = 1'b0;
         wr_val  = value_q;
         for (int j = 0; j < write_port_cnt; j++) begin
            if (wb_en[j] && wb_addr[j*aw +: aw] == ra) begin
               wr_hit = 1'b1;
               wr_val = wb_data[j*xlen +: xlen];
               if (wb_tag[j*tag_w +: tag_w] == tag_q)
                  tag_hit = 1'b1;
            end
         end
      end

      assign rsv_hit = rsv_en && (rsv_addr == ra);

      // A new reservation outranks both flush and a completing writeback.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            value_q <= '0;
            busy_q  <= 1'b0;
            tag_q   <= '0;
         end else if (en) begin
            if (wr_hit)
               value_q <= wr_val;
            if (rsv_hit) begin
               busy_q <= 1'b1;
               tag_q  <= rsv_tag;
            end else if (flush) begin
               busy_q <= 1'b0;
               tag_q  <= '0;
            end else if (busy_q && tag_hit) begin
               busy_q <= 1'b0;
               tag_q  <= '0;
            end
         end
      end

      assign val_flat[r*xlen +: xlen]   = value_q;
      assign busy_flat[r]               = busy_q;
      assign tag_flat[r*tag_w +: tag_w] = tag_q;
   end

   for (genvar i = 0; i < read_port_cnt; i++) begin : g_rd
      logic [aw-1:0]    a;
      logic [xlen-1:0]  d;
      logic             b;
      logic [tag_w-1:0] t;

      assign a = rd_addr[i*aw +: aw];

      // Writeback data and a completing tag are visible in the same cycle; reservations are not.
      always_comb begin
         d = val_flat[a*xlen +: xlen];
         b = busy_flat[a];
         t = tag_flat[a*tag_w +: tag_w];
         for (int j = 0; j < write_port_cnt; j++) begin
            if (wb_en[j] && wb_addr[j*aw +: aw] == a) begin
               d = wb_data[j*xlen +: xlen];
               if (wb_tag[j*tag_w +: tag_w] == tag_flat[a*tag_w +: tag_w])
                  b = 1'b0;
            end
         end
         if (!rst_n || a == '0) begin
            d = '0;
            b = 1'b0;
            t = '0;
         end
         if (!b)
            t = '0;
      end

      assign rd_data[i*xlen +: xlen]   = d;
      assign rd_busy[i]                = b;
      assign rd_tag[i*tag_w +: tag_w]  = t;
   end

endmodule

// File: tb/tb_scoreboard_regfile.sv
// tb/tb_scoreboard_regfile.sv - directed self-checking bench for scoreboard_regfile
module tb_scoreboard_regfile;
   localparam int xlen = 32;
   localparam int rc   = 32;
   localparam int np   = 4;
   localparam int nw   = 2;
   localparam int tw   = 4;
   localparam int aw   = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic [np*aw-1:0]   rd_addr;
   logic [np*xlen-1:0] rd_data;
   logic [np-1:0]      rd_busy;
   logic [np*tw-1:0]   rd_tag;
   logic              rsv_en;
   logic [aw-1:0]     rsv_addr;
   logic [tw-1:0]     rsv_tag;
   logic [nw-1:0]      wb_en;
   logic [nw*aw-1:0]   wb_addr;
   logic [nw*xlen-1:0] wb_data;
   logic [nw*tw-1:0]   wb_tag;
   logic              flush;

   int total  = 0;
   int passed = 0;

   scoreboard_regfile #(.xlen(xlen), .reg_cnt(rc), .read_port_cnt(np),
                        .write_port_cnt(nw), .tag_w(tw)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_tag(rsv_tag),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_tag(wb_tag),
      .flush(flush)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      rsv_en = 1'b0; rsv_addr = '0; rsv_tag = '0;
      wb_en = '0; wb_addr = '0; wb_data = '0; wb_tag = '0;
      flush = 1'b0;
   endtask

   task automatic set_rd(input int i, input logic [aw-1:0] a);
      rd_addr[i*aw +: aw] = a;
   endtask

   task automatic wb(input int j, input logic [aw-1:0] a, input logic [31:0] d, input logic [tw-1:0] t);
      wb_en[j] = 1'b1;
      wb_addr[j*aw +: aw] = a;
      wb_data[j*xlen +: xlen] = d;
      wb_tag[j*tw +: tw] = t;
   endtask

   task automatic rsv(input logic [aw-1:0] a, input logic [tw-1:0] t);
      rsv_en = 1'b1; rsv_addr = a; rsv_tag = t;
   endtask

   function automatic logic [31:0] dat(input int i);
      return rd_data[i*xlen +: xlen];
   endfunction

   function automatic logic [31:0] bsy(input int i);
      return {31'b0, rd_busy[i]};
   endfunction

   function automatic logic [31:0] tg(input int i);
      return {28'b0, rd_tag[i*tw +: tw]};
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b1; rd_addr = '0;
      clr_in();
      tick(); tick();
      rst_n = 1'b1;
      set_rd(0, 5'd1); set_rd(1, 5'd2);
      #2;
      chk("reset_data_x1", dat(0), 32'h0);
      chk("reset_busy_x2", bsy(1), 32'h0);

      // Populate x2 then pull reset mid-cycle
      wb(0, 5'd2, 32'hCAFE0001, 4'd0); rsv(5'd2, 4'd4);
      tick(); clr_in(); #2;
      chk("pre_rst_data_x2", dat(1), 32'hCAFE0001);
      chk("pre_rst_busy_x2", bsy(1), 32'h1);
      chk("pre_rst_tag_x2", tg(1), 32'h4);
      rst_n = 1'b0; #1;
      chk("async_rst_data_x2", dat(1), 32'h0);
      chk("async_rst_busy_x2", bsy(1), 32'h0);
      tick(); rst_n = 1'b1;

      // x0 ignores writes and reservations
      set_rd(0, 5'd0);
      wb(0, 5'd0, 32'hDEADBEEF, 4'd3); rsv(5'd0, 4'd3); #2;
      chk("x0_bypass_data", dat(0), 32'h0);
      tick(); clr_in(); #2;
      chk("x0_data", dat(0), 32'h0);
      chk("x0_busy", bsy(0), 32'h0);
      chk("x0_tag", tg(0), 32'h0);

      // Write/read with same-cycle bypass
      set_rd(1, 5'd5);
      wb(0, 5'd5, 32'h12345678, 4'd0); #2;
      chk("bypass_x5", dat(1), 32'h12345678);
      tick(); clr_in(); #2;
      chk("stored_x5", dat(1), 32'h12345678);

      // Two ports hit x7: higher port wins
      set_rd(2, 5'd7);
      wb(0, 5'd7, 32'h1, 4'd0); wb(1, 5'd7, 32'h2, 4'd0); #2;
      chk("bypass_x7_prio", dat(2), 32'h2);
      tick(); clr_in(); #2;
      chk("stored_x7_prio", dat(2), 32'h2);

      // Reserve then complete with matching tag
      set_rd(3, 5'd3);
      rsv(5'd3, 4'd5); #2;
      chk("rsv_no_bypass", bsy(3), 32'h0);
      tick(); clr_in(); #2;
      chk("rsv_busy_x3", bsy(3), 32'h1);
      chk("rsv_tag_x3", tg(3), 32'h5);
      wb(0, 5'd3, 32'hAA, 4'd5); #2;
      chk("wb_match_bypass_busy", bsy(3), 32'h0);
      chk("wb_match_bypass_tag", tg(3), 32'h0);
      tick(); clr_in(); #2;
      chk("wb_match_busy", bsy(3), 32'h0);
      chk("wb_match_data", dat(3), 32'hAA);

      // Stale writeback keeps the newer producer
      rsv(5'd3, 4'd5); tick();
      rsv(5'd3, 4'd9); tick(); clr_in();
      wb(0, 5'd3, 32'h11, 4'd5); #2;
      chk("stale_bypass_data", dat(3), 32'h11);
      chk("stale_bypass_busy", bsy(3), 32'h1);
      tick(); clr_in(); #2;
      chk("stale_data", dat(3), 32'h11);
      chk("stale_busy", bsy(3), 32'h1);
      chk("stale_tag", tg(3), 32'h9);
      wb(1, 5'd3, 32'h22, 4'd9);
      tick(); clr_in(); #2;
      chk("newest_wb_busy", bsy(3), 32'h0);
      chk("newest_wb_data", dat(3), 32'h22);

      // Reservation beats a completing writeback on the same edge
      set_rd(0, 5'd4);
      rsv(5'd4, 4'd1); tick(); clr_in();
      rsv(5'd4, 4'd2); wb(0, 5'd4, 32'h44, 4'd1);
      tick(); clr_in(); #2;
      chk("rsv_vs_wb_busy", bsy(0), 32'h1);
      chk("rsv_vs_wb_tag", tg(0), 32'h2);
      chk("rsv_vs_wb_data", dat(0), 32'h44);

      // Flush with concurrent reservation
      set_rd(1, 5'd8); set_rd(2, 5'd6);
      rsv(5'd8, 4'd6); tick(); clr_in(); #2;
      chk("x8_busy_before_flush", bsy(1), 32'h1);
      flush = 1'b1; rsv(5'd6, 4'd7);
      tick(); clr_in(); #2;
      chk("flush_x8_busy", bsy(1), 32'h0);
      chk("flush_x8_tag", tg(1), 32'h0);
      chk("flush_x4_busy", bsy(0), 32'h0);
      chk("flush_rsv_x6_busy", bsy(2), 32'h1);
      chk("flush_rsv_x6_tag", tg(2), 32'h7);
      chk("flush_keeps_x4_data", dat(0), 32'h44);

      // Enable low freezes state but not the read/bypass path
      set_rd(3, 5'd9);
      en = 1'b0; wb(0, 5'd9, 32'h55, 4'd0); rsv(5'd9, 4'd1); #2;
      chk("en0_bypass_x9", dat(3), 32'h55);
      tick(); clr_in(); #2;
      chk("en0_x9_data", dat(3), 32'h0);
      chk("en0_x9_busy", bsy(3), 32'h0);
      en = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed hang expected finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/scoreboard_regfile.md
Name: scoreboard_regfile

Overview:
- Parametrised multi-port integer register file with an integrated per-register scoreboard for the out-of-order core back end.
- Extends the current register file with:
  - configurable register count, width and port count;
  - an active-low asynchronous reset;
  - a reservation (issue) port that marks a destination register busy with a producer tag;
  - tag-qualified writeback that clears busy only for the latest producer;
  - a global flush.
- Sits between decode/issue (reservation, operand reads) and the writeback stage.

Parameters:
- xlen, 32, register data width in bits.
- reg_cnt, 32, number of architectural registers including x0; power of two, at least 2.
- read_port_cnt, 4, number of read ports, each returning one operand.
- write_port_cnt, 2, number of writeback ports.
- tag_w, 4, producer tag width in bits.
- Derived localparam aw = $clog2(reg_cnt).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; when 0, reservation, writeback and flush are all ignored, and reads stay live.
- rd_addr  in  read_port_cnt*aw  read register numbers; port i occupies slice i.
- rd_data  out  read_port_cnt*xlen  read values.
- rd_busy  out  read_port_cnt  register has an outstanding producer after bypass.
- rd_tag  out  read_port_cnt*tag_w  producer tag when rd_busy=1, else 0.
- rsv_en  in  1  reserve a destination register this cycle.
- rsv_addr  in  aw  register to reserve.
- rsv_tag  in  tag_w  producer tag to record.
- wb_en  in  write_port_cnt  writeback valid per port.
- wb_addr  in  write_port_cnt*aw  writeback register numbers.
- wb_data  in  write_port_cnt*xlen  writeback values.
- wb_tag  in  write_port_cnt*tag_w  producing tag per writeback port.
- flush  in  1  clear all busy bits; register data is kept.

Behaviour:
- State per register r = 1..reg_cnt-1: value[r], busy[r], tag[r]. No storage exists for x0.
- Reset (rst_n=0, asynchronous): all values 0, all busy 0, all tags 0. Outputs depend only on state and inputs, so rd_data, rd_busy and rd_tag read 0 for every address during reset.
- Reads are combinational (0-cycle latency):
  - Address 0 always returns data 0, busy 0, tag 0, regardless of any write, reservation or bypass.
  - Data bypass: if any wb_en[j] targets the read address, rd_data takes that wb_data. If several match, the highest j wins.
  - Busy bypass: if a matching wb_tag[j] equals the stored tag, rd_busy reads 0.
  - Reservations are not bypassed to reads in the same cycle.
- Writeback (rising edge, en=1, rst_n=1), for each j with wb_en[j]=1 and wb_addr[j]≠0:
  - value is written unconditionally; the highest j wins on an address conflict.
  - busy is cleared only if busy=1 and wb_tag[j] equals the stored tag.
  - A stale tag writes data but leaves busy and tag unchanged.
- Reservation (same edge), when rsv_en=1 and rsv_addr≠0: busy is set to 1 and tag is set to rsv_tag.
- Reservation vs writeback on the same register in the same edge: the reservation wins for busy/tag; the data write still occurs.
- A reservation on an already-busy register overwrites the tag, since the newest producer wins.
- Reservation to x0 is ignored.
- Flush (same edge): all busy bits and tags go to 0. Writebacks in that cycle still write data.
- Flush vs reservation in the same cycle: flush is applied first, then the reservation. The reserved register ends busy with the new tag.
- en=0: no state changes; reads and bypass outputs remain valid.
- Reset asserted mid-operation: state clears immediately without waiting for a clock edge. The first edge after deassertion obeys normal rules.

Test Plan:
- Reset and x0:
  - Stimulus: assert rst_n=0 mid-cycle; then write 0xDEADBEEF to x0 and reserve x0 with tag 3.
  - Required: all reads are 0 immediately on reset; x0 then reads data 0, busy 0.
- Write/read and bypass:
  - Stimulus: wb port 0 writes x5=0x12345678.
  - Required: a same-cycle read of x5 returns 0x12345678 combinationally; the next cycle also returns 0x12345678.
  - Stimulus: ports 0 and 1 both write x7 (0x1, 0x2).
  - Required: x7 reads 0x2.
- Scoreboard tag match:
  - Stimulus: reserve x3 tag 5, wait one cycle.
  - Required: rd_busy=1, rd_tag=5.
  - Stimulus: writeback x3 tag 5, data 0xAA.
  - Required: same-cycle busy=0; next cycle busy=0, data 0xAA.
- Stale writeback:
  - Stimulus: reserve x3 tag 5, then reserve x3 tag 9, then writeback x3 tag 5, data 0x11.
  - Required: data 0x11, busy=1, tag=9.
  - Stimulus: writeback x3 tag 9.
  - Required: busy clears.
- Simultaneous events:
  - Stimulus: same edge reserves x4 tag 2 and writes back x4 with matching old tag 1.
  - Required: busy=1, tag=2, data updated.
  - Stimulus: flush with reserve x6 tag 7 while x8 is busy.
  - Required: x8 not busy; x6 busy with tag 7.
- Enable gating:
  - Stimulus: en=0 with writeback x9=0x55 and rsv x9.
  - Required: x9 unchanged after the edge; bypass read still shows 0x55 during that cycle.
